// File: rtl/rng_ctrl_mc_pkg.sv
// rng_ctrl_mc_pkg: shared types and derived-size helpers for the multi-channel
// TRNG controller (rng_ctrl_mc) and its packer (rng_pack_mc).
//   group_w        : bits gathered per strobe (NUM_CH * TAKE_BITS)
//   strobes        : strobes needed to fill one output word
//   bytes_per_word : bytes carried by one output word
//   ovf_mode_e     : overflow policy selected by the host
package rng_ctrl_mc_pkg;

    typedef enum logic {
        OVF_DROP = 1'b0,   // lose the word, keep capturing
        OVF_HALT = 1'b1    // lose the word, stop capturing
    } ovf_mode_e;

    function automatic int group_w(input int num_ch, input int take_bits);
        return num_ch * take_bits;
    endfunction

    function automatic int strobes(input int out_w, input int num_ch, input int take_bits);
        return out_w / (num_ch * take_bits);
    endfunction

    function automatic int bytes_per_word(input int out_w);
        return out_w / 8;
    endfunction

endpackage

// File: rtl/rng_pack_mc.sv
// rng_pack_mc: shift/pack register and strobe counter.
// Each enabled cycle appends one group of sampler bits below the retained
// older bits; the oldest group therefore ends up in the word MSBs.
// Ports:
//   clk_i, rst_i   clock, async active-high reset
//   clr_i          synchronous clear (host STOP)
//   en_i           accept group_i this cycle
//   group_i        GROUP_W bits gathered from all channels
//   word_o         packed value including the current group (combinational)
//   done_o         this strobe completes a word (counter at its last value)
module rng_pack_mc
    import rng_ctrl_mc_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int TAKE_BITS = 1,
    parameter int OUT_W     = 32
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   clr_i,
    input  logic                                   en_i,
    input  logic [group_w(NUM_CH, TAKE_BITS)-1:0]  group_i,
    output logic [OUT_W-1:0]                       word_o,
    output logic                                   done_o
);

    localparam int GW = group_w(NUM_CH, TAKE_BITS);
    localparam int ST = strobes(OUT_W, NUM_CH, TAKE_BITS);
    localparam int CW = (ST > 1) ? $clog2(ST) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign done_o = (cnt_q == CW'(ST - 1));
    assign cnt_d  = done_o ? '0 : cnt_q + CW'(1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)      cnt_q <= '0;
        else if (clr_i) cnt_q <= '0;
        else if (en_i)  cnt_q <= cnt_d;
    end

    // Only the bits that survive into the next word are stored; the top
    // group of the current word is shifted out on the next strobe anyway.
    if (OUT_W == GW) begin : g_single
        assign word_o = group_i;
    end else begin : g_shift
        logic [OUT_W-GW-1:0] pack_q;

        assign word_o = {pack_q, group_i};

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i)      pack_q <= '0;
            else if (clr_i) pack_q <= '0;
            else if (en_i)  pack_q <= word_o[OUT_W-GW-1:0];
        end
    end

endmodule

// File: rtl/rng_ctrl_mc.sv
// rng_ctrl_mc: multi-channel TRNG controller.
// Packs TAKE_BITS LSBs of every channel per strobe into OUT_W-bit words and
// writes {last, word} to the output FIFO, tracking a host byte limit, a DMA
// frame length, a wrapping 32-bit sample sum and an overflow policy.
// Optional build macro: RNG_CTRL_MC_DROPCNT_EN adds DROPPED, a saturating
// count of words lost to FIFO_FULL (cleared by RST and STOP).
// Ports:
//   CLK, RST                clock, async active-high reset
//   DATA_IN, DATA_RE        channel samples and their common strobe
//   DATA_OUT, DATA_WE       {last, word} and FIFO write strobe
//   FIFO_FULL               FIFO cannot accept a write
//   GO, STOP                start pulse; stop/clear pulse (STOP wins)
//   OVF_MODE                0: drop and continue, 1: drop and halt
//   SEND_BYTES, DMA_BYTES   byte limit (0 = unlimited), DMA frame length
//   RUN, OVER               capture active, sticky overflow
//   SENT_BYTES, SUM_DATA    bytes written, sum of accepted samples
module rng_ctrl_mc
    import rng_ctrl_mc_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int SAMPLE_W  = 16,
    parameter int TAKE_BITS = 1,
    parameter int OUT_W     = 32
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [NUM_CH*SAMPLE_W-1:0]   DATA_IN,
    input  logic                         DATA_RE,
    output logic [OUT_W:0]               DATA_OUT,
    output logic                         DATA_WE,
    input  logic                         FIFO_FULL,
    input  logic                         GO,
    input  logic                         STOP,
    input  logic                         OVF_MODE,
    input  logic [31:0]                  SEND_BYTES,
    input  logic [31:0]                  DMA_BYTES,
    output logic                         RUN,
    output logic                         OVER,
    output logic [31:0]                  SENT_BYTES,
    output logic [31:0]                  SUM_DATA
`ifdef RNG_CTRL_MC_DROPCNT_EN
   ,output logic [31:0]                  DROPPED
`endif
);

    localparam int GW  = group_w(NUM_CH, TAKE_BITS);
    localparam int BPW = bytes_per_word(OUT_W);

    if ((TAKE_BITS < 1) || (TAKE_BITS > SAMPLE_W) ||
        (OUT_W % 8 != 0) || (OUT_W % GW != 0)) begin : g_bad_cfg
        $error("rng_ctrl_mc: OUT_W must be a multiple of 8 and of NUM_CH*TAKE_BITS");
    end

    logic              run_q, run_d;
    logic              over_q, over_d;
    logic [31:0]       sent_q, sent_d;
    logic [31:0]       sum_q, sum_d;
    logic [31:0]       dma_q, dma_d;

    logic [GW-1:0]     group;
    logic [OUT_W-1:0]  packed_word;
    logic              cmpl_strobe;
    logic              capture;
    logic              cmpl;
    logic              word_we;
    logic              last;
    logic              keep_run;
    logic [31:0]       samp_sum;
    logic [32:0]       dma_next;
    logic [31:0]       sent_next;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_grp
        assign group[c*TAKE_BITS +: TAKE_BITS] = DATA_IN[c*SAMPLE_W +: TAKE_BITS];
    end

    always_comb begin
        samp_sum = '0;
        for (int c = 0; c < NUM_CH; c++)
            samp_sum = samp_sum + 32'(DATA_IN[c*SAMPLE_W +: SAMPLE_W]);
    end

    // GO and STOP both swallow a coincident strobe.
    assign capture = run_q & DATA_RE & ~STOP & ~GO;
    assign cmpl    = capture & cmpl_strobe;
    assign word_we = cmpl & ~FIFO_FULL;

    // 33-bit compare so a frame length near 2^32 cannot wrap the test.
    assign dma_next  = {1'b0, dma_q} + 33'(BPW);
    assign last      = (dma_next >= {1'b0, DMA_BYTES});
    assign sent_next = sent_q + 32'(BPW);
    // Limit is checked after the increment, so a ragged limit rounds up.
    assign keep_run  = (SEND_BYTES == '0) || (sent_next < SEND_BYTES);

    rng_pack_mc #(
        .NUM_CH    (NUM_CH),
        .TAKE_BITS (TAKE_BITS),
        .OUT_W     (OUT_W)
    ) u_pack (
        .clk_i   (CLK),
        .rst_i   (RST),
        .clr_i   (STOP),
        .en_i    (capture),
        .group_i (group),
        .word_o  (packed_word),
        .done_o  (cmpl_strobe)
    );

    always_comb begin
        run_d  = run_q;
        over_d = over_q;
        sent_d = sent_q;
        sum_d  = sum_q;
        dma_d  = dma_q;
        if (STOP) begin
            run_d  = 1'b0;
            over_d = 1'b0;
            sent_d = '0;
            sum_d  = '0;
            dma_d  = '0;
        end else if (GO) begin
            run_d = 1'b1;
        end else if (capture) begin
            sum_d = sum_q + samp_sum;
            if (word_we) begin
                sent_d = sent_next;
                dma_d  = last ? '0 : dma_next[31:0];
                run_d  = keep_run;
            end else if (cmpl) begin
                over_d = 1'b1;
                if (ovf_mode_e'(OVF_MODE) == OVF_HALT) run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            run_q  <= 1'b0;
            over_q <= 1'b0;
            sent_q <= '0;
            sum_q  <= '0;
            dma_q  <= '0;
        end else begin
            run_q  <= run_d;
            over_q <= over_d;
            sent_q <= sent_d;
            sum_q  <= sum_d;
            dma_q  <= dma_d;
        end
    end

`ifdef RNG_CTRL_MC_DROPCNT_EN
    logic [31:0] drop_q, drop_d;

    always_comb begin
        drop_d = drop_q;
        if (STOP)                                          drop_d = '0;
        else if (cmpl && FIFO_FULL && (drop_q != '1))      drop_d = drop_q + 32'd1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) drop_q <= '0;
        else     drop_q <= drop_d;
    end

    assign DROPPED = drop_q;
`endif

    assign DATA_WE    = word_we;
    assign DATA_OUT   = {word_we & last, packed_word};
    assign RUN        = run_q;
    assign OVER       = over_q;
    assign SENT_BYTES = sent_q;
    assign SUM_DATA   = sum_q;

endmodule

// File: tb/tb_rng_ctrl_mc.sv
// tb_rng_ctrl_mc: randomized scoreboard bench for rng_ctrl_mc (default params).
// The reference model collects groups in a queue and forms a word once enough
// groups are present; expected FIFO writes go into a queue that a negedge
// monitor pops whenever DATA_WE is seen. Status outputs are compared against
// the model right after every clock edge.
module tb_rng_ctrl_mc;

    localparam int NC  = 4;
    localparam int SW  = 16;
    localparam int TB  = 1;
    localparam int OW  = 32;
    localparam int GW  = NC * TB;
    localparam int ST  = OW / GW;
    localparam int BPW = OW / 8;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic [NC*SW-1:0]  DATA_IN = '0;
    logic              DATA_RE = 1'b0;
    logic [OW:0]       DATA_OUT;
    logic              DATA_WE;
    logic              FIFO_FULL = 1'b0;
    logic              GO = 1'b0;
    logic              STOP = 1'b0;
    logic              OVF_MODE = 1'b0;
    logic [31:0]       SEND_BYTES = '0;
    logic [31:0]       DMA_BYTES = '0;
    logic              RUN;
    logic              OVER;
    logic [31:0]       SENT_BYTES;
    logic [31:0]       SUM_DATA;
`ifdef RNG_CTRL_MC_DROPCNT_EN
    logic [31:0]       DROPPED;
`endif

    rng_ctrl_mc dut (
        .CLK        (CLK),
        .RST        (RST),
        .DATA_IN    (DATA_IN),
        .DATA_RE    (DATA_RE),
        .DATA_OUT   (DATA_OUT),
        .DATA_WE    (DATA_WE),
        .FIFO_FULL  (FIFO_FULL),
        .GO         (GO),
        .STOP       (STOP),
        .OVF_MODE   (OVF_MODE),
        .SEND_BYTES (SEND_BYTES),
        .DMA_BYTES  (DMA_BYTES),
        .RUN        (RUN),
        .OVER       (OVER),
        .SENT_BYTES (SENT_BYTES),
        .SUM_DATA   (SUM_DATA)
`ifdef RNG_CTRL_MC_DROPCNT_EN
       ,.DROPPED    (DROPPED)
`endif
    );

    always #5 CLK = ~CLK;

    int vecs = 0;
    int errs = 0;

    // reference model state
    bit            m_run, m_over;
    logic [31:0]   m_sent, m_sum, m_dma, m_drop;
    int unsigned   grp_q[$];
    logic [OW:0]   exp_q[$];

    // next-cycle stimulus
    logic              nx_stop, nx_go, nx_re, nx_full, nx_ovf;
    logic [NC*SW-1:0]  nx_din;
    logic [31:0]       nx_send, nx_dma;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_over = 0;
        m_sent = '0; m_sum = '0; m_dma = '0; m_drop = '0;
        grp_q.delete();
        exp_q.delete();
    endtask

    task automatic model_step();
        int unsigned g;
        logic [OW-1:0] w;
        bit lst;
        if (nx_stop) begin
            m_run = 0; m_over = 0;
            m_sent = '0; m_sum = '0; m_dma = '0; m_drop = '0;
            grp_q.delete();
        end else if (nx_go) begin
            m_run = 1;
        end else if (m_run && nx_re) begin
            g = 0;
            for (int c = 0; c < NC; c++) begin
                m_sum = m_sum + 32'(nx_din[c*SW +: SW]);
                g = g | (((nx_din >> (c*SW)) & ((64'd1 << TB) - 1)) << (c*TB));
            end
            grp_q.push_back(g);
            if (grp_q.size() == ST) begin
                w = '0;
                foreach (grp_q[i]) w = (w << GW) | OW'(grp_q[i]);
                grp_q.delete();
                if (!nx_full) begin
                    lst = (longint'(m_dma) + BPW) >= longint'(nx_dma);
                    exp_q.push_back({lst, w});
                    m_dma  = lst ? 32'd0 : m_dma + BPW;
                    m_sent = m_sent + BPW;
                    m_run  = (nx_send == 0) || (m_sent < nx_send);
                end else begin
                    m_over = 1;
                    if (m_drop != 32'hFFFF_FFFF) m_drop = m_drop + 1;
                    if (nx_ovf) m_run = 0;
                end
            end
        end
    endtask

    // One clock: check registered status, then present this cycle's inputs.
    task automatic drive();
        @(posedge CLK);
        #1;
        chk("RUN", 32'(RUN), 32'(m_run));
        chk("OVER", 32'(OVER), 32'(m_over));
        chk("SENT_BYTES", SENT_BYTES, m_sent);
        chk("SUM_DATA", SUM_DATA, m_sum);
`ifdef RNG_CTRL_MC_DROPCNT_EN
        chk("DROPPED", DROPPED, m_drop);
`endif
        STOP = nx_stop; GO = nx_go; DATA_RE = nx_re; FIFO_FULL = nx_full;
        DATA_IN = nx_din; OVF_MODE = nx_ovf; SEND_BYTES = nx_send; DMA_BYTES = nx_dma;
        model_step();
    endtask

    task automatic cyc(input logic stop, input logic go, input logic re,
                       input logic full, input logic [NC*SW-1:0] din);
        nx_stop = stop; nx_go = go; nx_re = re; nx_full = full; nx_din = din;
        drive();
    endtask

    // Reset asserted mid-cycle while a word may be completing.
    task automatic mid_reset();
        #2;
        RST = 1'b1;
        model_reset();
        #1;
        chk("RUN during RST", 32'(RUN), 32'd0);
        chk("DATA_WE during RST", 32'(DATA_WE), 32'd0);
        STOP = 0; GO = 0; DATA_RE = 0; FIFO_FULL = 0;
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    // scoreboard monitor
    initial begin
        logic [OW:0] e;
        forever begin
            @(negedge CLK);
            if (DATA_WE) begin
                vecs++;
                if (exp_q.size() == 0) begin
                    errs++;
                    $display("FAIL unexpected write: got %h expected none at %0t", DATA_OUT, $time);
                end else begin
                    e = exp_q.pop_front();
                    if (DATA_OUT !== e) begin
                        errs++;
                        $display("FAIL DATA_OUT: got %h expected %h at %0t", DATA_OUT, e, $time);
                    end
                end
            end else if (exp_q.size() != 0) begin
                vecs++;
                errs++;
                $display("FAIL missing write: got none expected %h at %0t", exp_q[0], $time);
                exp_q.delete();
            end
        end
    end

    localparam logic [NC*SW-1:0] PAT_B = 64'h0001_0000_0001_0001; // ch3..0 LSB = 1,0,1,1
    localparam logic [NC*SW-1:0] ALL_F = 64'hFFFF_FFFF_FFFF_FFFF;

    initial begin
        nx_stop = 0; nx_go = 0; nx_re = 0; nx_full = 0; nx_ovf = 0;
        nx_din = '0; nx_send = '0; nx_dma = 32'd8;
        model_reset();
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RST = 1'b0;

        // basic packing and DMA framing: 0xBBBBBBBB, last 0 then 1
        cyc(0, 0, 0, 0, '0);
        cyc(0, 1, 1, 0, PAT_B);            // strobe with GO is ignored
        repeat (16) cyc(0, 0, 1, 0, PAT_B);
        repeat (3) cyc(0, 0, 0, 0, '0);

        // byte limit: RUN drops after second word
        cyc(1, 0, 0, 0, '0);
        nx_send = 32'd8;
        cyc(0, 1, 0, 0, '0);
        repeat (24) cyc(0, 0, 1, 0, {$urandom, $urandom});
        // ragged limit rounds up to whole words
        cyc(1, 0, 0, 0, '0);
        nx_send = 32'd5;
        cyc(0, 1, 0, 0, '0);
        repeat (24) cyc(0, 0, 1, 0, {$urandom, $urandom});

        // overflow, drop and continue
        cyc(1, 0, 0, 0, '0);
        nx_send = 32'd0; nx_ovf = 0;
        cyc(0, 1, 0, 0, '0);
        repeat (7) cyc(0, 0, 1, 0, {$urandom, $urandom});
        cyc(0, 0, 1, 1, {$urandom, $urandom});
        repeat (8) cyc(0, 0, 1, 0, {$urandom, $urandom});

        // overflow, drop and halt
        cyc(1, 0, 0, 0, '0);
        nx_ovf = 1;
        cyc(0, 1, 0, 0, '0);
        repeat (7) cyc(0, 0, 1, 0, {$urandom, $urandom});
        cyc(0, 0, 1, 1, {$urandom, $urandom});
        repeat (8) cyc(0, 0, 1, 0, {$urandom, $urandom});

        // STOP and GO together mid-word
        cyc(0, 1, 0, 0, '0);
        repeat (3) cyc(0, 0, 1, 0, {$urandom, $urandom});
        cyc(1, 1, 1, 0, {$urandom, $urandom});
        cyc(0, 0, 1, 0, {$urandom, $urandom});

        // RST mid-word, on the completing strobe
        nx_ovf = 0;
        cyc(0, 1, 0, 0, '0);
        repeat (7) cyc(0, 0, 1, 0, {$urandom, $urandom});
        cyc(0, 0, 1, 0, {$urandom, $urandom});
        mid_reset();
        cyc(0, 0, 1, 0, {$urandom, $urandom});

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) begin
                nx_ovf  = 1'($urandom);
                nx_send = ($urandom % 3 == 0) ? 32'd0 : 32'($urandom_range(1, 48));
                nx_dma  = ($urandom % 5 == 0) ? 32'd0 : 32'($urandom_range(1, 24));
            end
            cyc(($urandom % 97) == 0, ($urandom % 13) == 0, ($urandom % 4) != 0,
                ($urandom % 5) == 0, {$urandom, $urandom});
        end

        // 32-bit sum wrap: 16385 strobes of 0xFFFF on every channel
        cyc(1, 0, 0, 0, '0);
        nx_send = 32'd0; nx_ovf = 0; nx_dma = 32'd64;
        cyc(0, 1, 0, 0, '0);
        repeat (16385) cyc(0, 0, 1, ($urandom % 7) == 0, ALL_F);
        cyc(0, 0, 0, 0, '0);
        chk("SUM_DATA wrap", SUM_DATA, 32'h0002_FFFC);
        cyc(0, 0, 0, 0, '0);

        @(posedge CLK);
        #1;
        chk("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
